// File: rtl/nap_timer_bank.sv
// nap_timer_bank: N independent BCD HH:MM:SS countdown channels sharing a single one-second prescaler.
// Optional feature macro NAP_OVERSLEEP_EN: expired channels count oversleep time upward, saturating at 23:59:59.
module nap_timer_bank #(
  parameter int N          = 4,
  parameter int CH_W       = 2,
  parameter int TICK_DIV   = 50000000,
  parameter int SNOOZE_MIN = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load_en,
  input  logic [CH_W-1:0] load_ch,
  input  logic [23:0]     load_time,
  input  logic [N-1:0]    start,
  input  logic [N-1:0]    pause,
  input  logic [N-1:0]    snooze,
  input  logic [CH_W-1:0] sel_ch,
  output logic [23:0]     sel_time,
  output logic [N-1:0]    running,
  output logic [N-1:0]    expired,
  output logic [N-1:0]    expire_pulse,
  output logic            any_expired,
  output logic            load_err
);

  localparam int              PW          = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_MAX   = PW'(TICK_DIV - 1);
  localparam logic [23:0]     SNOOZE_TIME = {8'h00, 4'(SNOOZE_MIN / 10), 4'(SNOOZE_MIN % 10), 8'h00};
  localparam logic [CH_W:0]   N_CH        = (CH_W + 1)'(N);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } chan_state_t;

  function automatic logic bcd_time_valid(input logic [23:0] t);
    logic ok;
    ok = (t[23:20] <= 4'd2) && (t[19:16] <= 4'd9) && (t[15:12] <= 4'd5) &&
         (t[11:8] <= 4'd9) && (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
    if ((t[23:20] == 4'd2) && (t[19:16] > 4'd3)) ok = 1'b0;
    return ok;
  endfunction

  // Borrow ripples s1 -> s10 -> m1 -> m10 -> h1 -> h10; never called on 00:00:00.
  function automatic logic [23:0] bcd_dec(input logic [23:0] t);
    logic [23:0] r;
    r = t;
    if (r[3:0] != 4'd0) r[3:0] = r[3:0] - 4'd1;
    else begin
      r[3:0] = 4'd9;
      if (r[7:4] != 4'd0) r[7:4] = r[7:4] - 4'd1;
      else begin
        r[7:4] = 4'd5;
        if (r[11:8] != 4'd0) r[11:8] = r[11:8] - 4'd1;
        else begin
          r[11:8] = 4'd9;
          if (r[15:12] != 4'd0) r[15:12] = r[15:12] - 4'd1;
          else begin
            r[15:12] = 4'd5;
            if (r[19:16] != 4'd0) r[19:16] = r[19:16] - 4'd1;
            else begin
              r[19:16] = 4'd9;
              r[23:20] = r[23:20] - 4'd1;
            end
          end
        end
      end
    end
    return r;
  endfunction

`ifdef NAP_OVERSLEEP_EN
  function automatic logic [23:0] bcd_inc_sat(input logic [23:0] t);
    logic [23:0] r;
    r = t;
    if (t == 24'h235959) r = t;
    else if (r[3:0] != 4'd9) r[3:0] = r[3:0] + 4'd1;
    else begin
      r[3:0] = 4'd0;
      if (r[7:4] != 4'd5) r[7:4] = r[7:4] + 4'd1;
      else begin
        r[7:4] = 4'd0;
        if (r[11:8] != 4'd9) r[11:8] = r[11:8] + 4'd1;
        else begin
          r[11:8] = 4'd0;
          if (r[15:12] != 4'd5) r[15:12] = r[15:12] + 4'd1;
          else begin
            r[15:12] = 4'd0;
            if (r[19:16] != 4'd9) r[19:16] = r[19:16] + 4'd1;
            else begin
              r[19:16] = 4'd0;
              r[23:20] = r[23:20] + 4'd1;
            end
          end
        end
      end
    end
    return r;
  endfunction
`endif

  logic [PW-1:0] presc_r;
  chan_state_t   state_r [N];
  logic [23:0]   time_r  [N];
  logic [23:0]   sel_time_r;
  logic [N-1:0]  running_r;
  logic [N-1:0]  expired_r;
  logic [N-1:0]  expire_pulse_r;
  logic          load_err_r;

  logic          tick_s;
  logic          load_ok_s;
  logic [N-1:0]  load_hit_s;
  logic [N-1:0]  start_s;
  logic [23:0]   sel_time_s;

  // Tick, load qualification and readout mux; pause masks a simultaneous start.
  always_comb begin
    tick_s     = (presc_r == PRESC_MAX);
    load_ok_s  = bcd_time_valid(load_time) && ({1'b0, load_ch} < N_CH);
    start_s    = start & ~pause;
    load_hit_s = '0;
    for (int i = 0; i < N; i++) begin
      if (load_en && load_ok_s && (load_ch == CH_W'(i))) load_hit_s[i] = 1'b1;
      else load_hit_s[i] = 1'b0;
    end
    if ({1'b0, sel_ch} < N_CH) sel_time_s = time_r[sel_ch];
    else sel_time_s = 24'h000000;
  end

  // Prescaler and per-channel state machines with registered status outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_r        <= '0;
      sel_time_r     <= 24'h000000;
      running_r      <= '0;
      expired_r      <= '0;
      expire_pulse_r <= '0;
      load_err_r     <= 1'b0;
      for (int i = 0; i < N; i++) begin
        state_r[i] <= ST_IDLE;
        time_r[i]  <= 24'h000000;
      end
    end else begin
      presc_r    <= tick_s ? '0 : presc_r + 1'b1;
      load_err_r <= load_en & ~load_ok_s;
      sel_time_r <= sel_time_s;
      for (int i = 0; i < N; i++) begin
        expire_pulse_r[i] <= 1'b0;
        if (load_hit_s[i]) begin
          time_r[i]    <= load_time;
          state_r[i]   <= ST_IDLE;
          running_r[i] <= 1'b0;
          expired_r[i] <= 1'b0;
        end else begin
          case (state_r[i])
            ST_IDLE: begin
              if (start_s[i] && (time_r[i] == 24'h000000)) begin
                state_r[i]        <= ST_EXPIRED;
                expired_r[i]      <= 1'b1;
                expire_pulse_r[i] <= 1'b1;
              end else if (start_s[i]) begin
                state_r[i]   <= ST_RUN;
                running_r[i] <= 1'b1;
              end
            end
            ST_RUN: begin
              if (pause[i]) begin
                state_r[i]   <= ST_PAUSE;
                running_r[i] <= 1'b0;
              end else if (tick_s) begin
                time_r[i] <= bcd_dec(time_r[i]);
                if (bcd_dec(time_r[i]) == 24'h000000) begin
                  state_r[i]        <= ST_EXPIRED;
                  running_r[i]      <= 1'b0;
                  expired_r[i]      <= 1'b1;
                  expire_pulse_r[i] <= 1'b1;
                end
              end
            end
            ST_PAUSE: begin
              if (start_s[i]) begin
                state_r[i]   <= ST_RUN;
                running_r[i] <= 1'b1;
              end
            end
            ST_EXPIRED: begin
              if (snooze[i]) begin
                time_r[i]    <= SNOOZE_TIME;
                state_r[i]   <= ST_RUN;
                running_r[i] <= 1'b1;
                expired_r[i] <= 1'b0;
              end
`ifdef NAP_OVERSLEEP_EN
              else if (tick_s) begin
                time_r[i] <= bcd_inc_sat(time_r[i]);
              end
`endif
            end
            default: begin
              state_r[i]   <= ST_IDLE;
              running_r[i] <= 1'b0;
              expired_r[i] <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign sel_time     = sel_time_r;
  assign running      = running_r;
  assign expired      = expired_r;
  assign expire_pulse = expire_pulse_r;
  assign load_err     = load_err_r;
  assign any_expired  = |expired_r;

endmodule

// File: tb/tb_nap_timer_bank.sv
// Self-checking bench for nap_timer_bank: directed scenarios plus random traffic against a seconds-based model.
module tb_nap_timer_bank;
  localparam int N          = 4;
  localparam int CH_W       = 3;
  localparam int TICK_DIV   = 4;
  localparam int SNOOZE_MIN = 5;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_EXP = 3;

  logic            clock, reset, load_en, any_expired, load_err;
  logic [CH_W-1:0] load_ch, sel_ch;
  logic [23:0]     load_time, sel_time;
  logic [N-1:0]    start, pause, snooze, running, expired, expire_pulse;

  int n_checks = 0;
  int n_pass   = 0;
  int m_sec [N];
  int m_st  [N];
  bit m_pulse [N];
  bit m_lerr;
  int m_presc;
  int m_sel;

  nap_timer_bank #(.N(N), .CH_W(CH_W), .TICK_DIV(TICK_DIV), .SNOOZE_MIN(SNOOZE_MIN)) dut (
    .clock(clock), .reset(reset), .load_en(load_en), .load_ch(load_ch), .load_time(load_time),
    .start(start), .pause(pause), .snooze(snooze), .sel_ch(sel_ch), .sel_time(sel_time),
    .running(running), .expired(expired), .expire_pulse(expire_pulse),
    .any_expired(any_expired), .load_err(load_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [23:0] to_bcd(input int s);
    int h, m, x;
    h = s / 3600;
    m = (s / 60) % 60;
    x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_sec[i] = 0; m_st[i] = S_IDLE; m_pulse[i] = 1'b0;
    end
    m_lerr = 1'b0; m_presc = 0; m_sel = 0;
  endtask

  task automatic model_edge();
    bit tick, valid, se;
    int h, m, s, sel_next, idx;
    tick = (m_presc == TICK_DIV - 1);
    m_presc = tick ? 0 : m_presc + 1;
    idx = int'(sel_ch);
    sel_next = 0;
    if (idx < N) sel_next = m_sec[idx];
    valid = 1'b1;
    for (int k = 0; k < 6; k++) if (load_time[4*k +: 4] > 4'd9) valid = 1'b0;
    h = 10 * int'(load_time[23:20]) + int'(load_time[19:16]);
    m = 10 * int'(load_time[15:12]) + int'(load_time[11:8]);
    s = 10 * int'(load_time[7:4]) + int'(load_time[3:0]);
    if (h > 23 || m > 59 || s > 59 || int'(load_ch) >= N) valid = 1'b0;
    m_lerr = load_en && !valid;
    for (int i = 0; i < N; i++) begin
      m_pulse[i] = 1'b0;
      se = start[i] && !pause[i];
      if (load_en && valid && int'(load_ch) == i) begin
        m_sec[i] = h * 3600 + m * 60 + s;
        m_st[i]  = S_IDLE;
      end else if (m_st[i] == S_IDLE) begin
        if (se && m_sec[i] == 0) begin m_st[i] = S_EXP; m_pulse[i] = 1'b1; end
        else if (se) m_st[i] = S_RUN;
      end else if (m_st[i] == S_RUN) begin
        if (pause[i]) m_st[i] = S_PAUSE;
        else if (tick) begin
          m_sec[i]--;
          if (m_sec[i] == 0) begin m_st[i] = S_EXP; m_pulse[i] = 1'b1; end
        end
      end else if (m_st[i] == S_PAUSE) begin
        if (se) m_st[i] = S_RUN;
      end else begin
        if (snooze[i]) begin m_sec[i] = SNOOZE_MIN * 60; m_st[i] = S_RUN; end
`ifdef NAP_OVERSLEEP_EN
        else if (tick && m_sec[i] < 86399) m_sec[i]++;
`endif
      end
    end
    m_sel = sel_next;
  endtask

  task automatic compare_all();
    logic [N-1:0] e_run, e_exp, e_pul;
    for (int i = 0; i < N; i++) begin
      e_run[i] = (m_st[i] == S_RUN);
      e_exp[i] = (m_st[i] == S_EXP);
      e_pul[i] = m_pulse[i];
    end
    check("running", 32'(running), 32'(e_run));
    check("expired", 32'(expired), 32'(e_exp));
    check("expire_pulse", 32'(expire_pulse), 32'(e_pul));
    check("any_expired", 32'(any_expired), 32'(|e_exp));
    check("load_err", 32'(load_err), 32'(m_lerr));
    check("sel_time", 32'(sel_time), 32'(to_bcd(m_sel)));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_load(input int ch, input logic [23:0] t);
    load_en = 1'b1; load_ch = CH_W'(ch); load_time = t;
    step();
    load_en = 1'b0;
  endtask

  task automatic pulse_in(input logic [N-1:0] st, input logic [N-1:0] pa, input logic [N-1:0] sn);
    start = st; pause = pa; snooze = sn;
    step();
    start = '0; pause = '0; snooze = '0;
  endtask

  initial begin
    int k;
    reset = 1'b0; load_en = 1'b0; load_ch = '0; load_time = 24'h000000;
    start = '0; pause = '0; snooze = '0; sel_ch = '0;
    model_reset();
    #3;
    compare_all();
    #9 reset = 1'b1;

    // Short countdown to expiry
    do_load(0, 24'h000003);
    pulse_in(4'b0001, 4'b0000, 4'b0000);
    check("t1_running0", 32'(running[0]), 32'd1);
    cycles(16);
    check("t1_expired0", 32'(expired[0]), 32'd1);
`ifndef NAP_OVERSLEEP_EN
    check("t1_time0", 32'(sel_time), 32'h000000);
`endif

    // Full borrow chain
    sel_ch = 3'd1;
    do_load(1, 24'h010000);
    pulse_in(4'b0010, 4'b0000, 4'b0000);
    cycles(5);
    check("t2_borrow", 32'(sel_time), 32'h005959);

    // Pause holds, resume without partial-second credit
    sel_ch = 3'd2;
    do_load(2, 24'h000010);
    pulse_in(4'b0100, 4'b0000, 4'b0000);
    cycles(8);
    pulse_in(4'b0000, 4'b0100, 4'b0000);
    cycles(20);
    check("t3_hold", 32'(sel_time), 32'h000008);
    pulse_in(4'b0100, 4'b0000, 4'b0000);
    cycles(5);
    check("t3_resume", 32'(sel_time), 32'h000007);

    // Rejected loads, then zero load + start
    sel_ch = 3'd0;
    do_load(0, 24'h240000);
    check("t4_err_hours", 32'(load_err), 32'd1);
    do_load(0, 24'h006000);
    check("t4_err_min", 32'(load_err), 32'd1);
    do_load(4, 24'h000005);
    check("t4_err_ch", 32'(load_err), 32'd1);
    step();
    check("t4_unchanged", 32'(expired[0]), 32'd1);
    do_load(0, 24'h000000);
    pulse_in(4'b0001, 4'b0000, 4'b0000);
    check("t4_zero_pulse", 32'(expire_pulse[0]), 32'd1);
    check("t4_zero_exp", 32'(expired[0]), 32'd1);

    // Simultaneous expiry of ch0 and ch3, then snooze ch3
    do_load(1, 24'h000000);
    do_load(2, 24'h000000);
    do_load(0, 24'h000001);
    do_load(3, 24'h000001);
    pulse_in(4'b1001, 4'b0000, 4'b0000);
    k = 0;
    while (expire_pulse == 4'b0000 && k < 12) begin step(); k++; end
    check("t5_pulse", 32'(expire_pulse), 32'h9);
    check("t5_any", 32'(any_expired), 32'd1);
    sel_ch = 3'd3;
    step();
    pulse_in(4'b0000, 4'b0000, 4'b1000);
    check("t5_snooze_run", 32'(running[3]), 32'd1);
    check("t5_snooze_exp", 32'(expired[3]), 32'd0);
    check("t5_any_kept", 32'(any_expired), 32'd1);
    step();
    check("t5_snooze_time", 32'(sel_time), 32'h000500);

    // Random traffic against the model, with one asynchronous reset mid-run
    for (int c = 0; c < 3000; c++) begin
      load_en = ($urandom_range(0, 7) == 0);
      load_ch = CH_W'($urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0) load_time = 24'($urandom);
      else load_time = to_bcd($urandom_range(0, 12));
      start  = N'($urandom) & N'($urandom);
      pause  = N'($urandom) & N'($urandom) & N'($urandom);
      snooze = N'($urandom) & N'($urandom);
      if ($urandom_range(0, 15) == 0) sel_ch = CH_W'($urandom_range(0, 5));
      step();
      if (c == 1500) begin
        #2 reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        #2 reset = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
